alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the entry count of both the instruction queue and the result queue.
REQ-002 SHALL have parameter ALU_LAT, default 1, the clock edges from the ALU sampling IW to the ALU registering result.
REQ-003 SHALL have parameter TAG_W, default 8, the sequence-tag width.
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_word.
REQ-007 in_ready  output  1  block accepts in_word this cycle.
REQ-008 in_word  input  instruction_t  instruction (a, b, opcode) from the definitions package.
REQ-009 alu_iw  output  instruction_t  registered word driving the ALU IW port.
REQ-010 alu_result  input  32  ALU result port.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream takes result.
REQ-013 out_result  output  32  head result.
REQ-014 out_tag  output  TAG_W  sequence tag of head result.
REQ-015 busy  output  1  any queued, in-flight or unread work.

Function
REQ-016 SHALL accept in_word on a posedge where in_valid && in_ready, writing {in_word, tag} into the instruction queue.
REQ-017 SHALL drive in_ready = (instruction-queue count < DEPTH) && !reset, independent of in_valid; a same-cycle pop at full does not raise in_ready.
REQ-018 SHALL assign tags from a counter, reset 0, incremented by 1 per accept and wrapping modulo 2^TAG_W.
REQ-019 SHALL issue at most one word per cycle: when the instruction queue is non-empty and (result-queue count + in-flight count) < DEPTH, load the head into alu_iw and pop it.
REQ-020 SHALL hold the last issued value on alu_iw when not issuing.
REQ-021 SHALL track in-flight words with a valid/tag shift register of length ALU_LAT+1, shifted every cycle.
REQ-022 SHALL write alu_result and the matching tag into the result queue on the posedge where the shift-register tail is valid (ALU_LAT+1 edges after the issue edge).
REQ-023 Credit rule (REQ-019) SHALL guarantee the result queue never overflows; no result is ever dropped outside reset.
REQ-024 SHALL drive out_valid = result queue non-empty, with out_result/out_tag = head entry, stable while out_valid && !out_ready.
REQ-025 SHALL pop the result queue on out_valid && out_ready; a simultaneous write and pop at any occupancy are both performed.
REQ-026 SHALL deliver results in strict acceptance order (consecutive tags).
REQ-027 busy SHALL be 1 iff either queue is non-empty or any shift-register stage is valid.
REQ-028 Sustained throughput SHALL be one accept and one result per cycle with out_ready held high.

Reset
REQ-029 While reset is high at a posedge: both queues emptied, shift register cleared, tag counter 0, alu_iw all-zero.
REQ-030 Outputs during/after reset: in_ready 0 during, 1 on the first cycle after; out_valid 0; out_result 0; out_tag 0; busy 0.
REQ-031 Reset mid-operation SHALL discard all queued and in-flight work; ALU results returning afterwards are ignored.

Verification
REQ-032 Single op: accept {a=5,b=7,ADD} at edge E0, out_ready=1 -> out_valid at E3, out_result=12, out_tag=0, busy 0 after pop.
REQ-033 Back-pressure: out_ready=0, in_valid held with 10 words -> exactly 8 accepted (4 queued + 4 credited), in_ready 0 thereafter; release out_ready -> results tags 0..7 in order, then remaining 2 accepted.
REQ-034 Streaming: 16 back-to-back ADDs (a=i,b=1), out_ready=1 -> out_valid continuous for 16 cycles, results i+1, tags 0..15.
REQ-035 Full with pop: queue full, issue occurring, in_valid=1 -> in_ready stays 0 that cycle; word accepted next cycle.
REQ-036 Reset mid-op: 3 words in flight, 2 results unread, assert reset 1 cycle -> out_valid 0, busy 0, in_ready 1 next cycle, next accepted tag 0, no stale result appears.
REQ-037 Tag wrap: 257 ops -> result 256 has out_tag 255, result 257 has out_tag 0.

Source files
------------

// File: rtl/alu_dispatch_if.sv
// Shared instruction types and the dispatch bus bundle (upstream, ALU and downstream sides).
package alu_dispatch_pkg;
  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR
  } opcode_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    opcode_t     opcode;
  } instruction_t;
endpackage

interface alu_dispatch_if #(
  parameter int unsigned TAG_W = 8
);
  import alu_dispatch_pkg::*;

  logic             in_valid;
  logic             in_ready;
  instruction_t     in_word;
  instruction_t     alu_iw;
  logic [31:0]      alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_word, alu_result, out_ready,
    input  in_ready, alu_iw, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_word, alu_result, out_ready,
    output in_ready, alu_iw, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/alu_dispatch.sv
// Credit-based dispatcher: instruction FIFO -> external ALU -> tagged result FIFO, results in acceptance order.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned TAG_W   = 8
) (
  input logic          clock,
  input logic          reset,
  alu_dispatch_if.slave bus
);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SR_LEN = ALU_LAT + 1;

  instruction_t     iq_word [DEPTH];
  logic [TAG_W-1:0] iq_tag  [DEPTH];
  logic [PTR_W-1:0] iq_head, iq_tail;
  logic [CNT_W-1:0] iq_count;

  logic [31:0]      rq_result [DEPTH];
  logic [TAG_W-1:0] rq_tag    [DEPTH];
  logic [PTR_W-1:0] rq_head, rq_tail;
  logic [CNT_W-1:0] rq_count;

  logic [SR_LEN-1:0] sr_valid;
  logic [TAG_W-1:0]  sr_tag [SR_LEN];
  logic [TAG_W-1:0]  next_tag;
  instruction_t      iw;

  logic accept, issue, rq_wr, rq_rd;
  int   credit_used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Results already queued plus words still in the ALU must fit the result FIFO.
  always_comb begin
    credit_used = int'(rq_count) + $countones(sr_valid);
    accept      = bus.in_valid && bus.in_ready;
    issue       = (iq_count != '0) && (credit_used < int'(DEPTH));
    rq_wr       = sr_valid[SR_LEN-1];
    rq_rd       = bus.out_valid && bus.out_ready;
  end

  assign bus.in_ready   = (iq_count < CNT_W'(DEPTH)) && !reset;
  assign bus.alu_iw     = iw;
  assign bus.out_valid  = (rq_count != '0);
  assign bus.out_result = bus.out_valid ? rq_result[rq_head] : '0;
  assign bus.out_tag    = bus.out_valid ? rq_tag[rq_head] : '0;
  assign bus.busy       = (iq_count != '0) || (rq_count != '0) || (|sr_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      iq_head  <= '0;
      iq_tail  <= '0;
      iq_count <= '0;
      rq_head  <= '0;
      rq_tail  <= '0;
      rq_count <= '0;
      sr_valid <= '0;
      next_tag <= '0;
      iw       <= '0;
    end else begin
      if (accept) begin
        iq_word[iq_tail] <= bus.in_word;
        iq_tag[iq_tail]  <= next_tag;
        iq_tail          <= next_ptr(iq_tail);
        next_tag         <= next_tag + TAG_W'(1);
      end
      if (issue) begin
        iw      <= iq_word[iq_head];
        iq_head <= next_ptr(iq_head);
      end
      iq_count <= iq_count + CNT_W'(accept) - CNT_W'(issue);

      sr_valid[0] <= issue;
      sr_tag[0]   <= iq_tag[iq_head];
      for (int unsigned i = 1; i < SR_LEN; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_tag[i]   <= sr_tag[i-1];
      end

      if (rq_wr) begin
        rq_result[rq_tail] <= bus.alu_result;
        rq_tag[rq_tail]    <= sr_tag[SR_LEN-1];
        rq_tail            <= next_ptr(rq_tail);
      end
      if (rq_rd) begin
        rq_head <= next_ptr(rq_head);
      end
      rq_count <= rq_count + CNT_W'(rq_wr) - CNT_W'(rq_rd);
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: one-stage ALU model, acceptance-order scoreboard, scenario tasks.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int TAG_W   = 8;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } rec_t;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   accept_cnt = 0;
  rec_t exp_q[$];
  rec_t got_q[$];

  alu_dispatch_if #(.TAG_W(TAG_W)) bus();

  alu_dispatch #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_alu(input instruction_t w);
    case (w.opcode)
      OP_ADD:  return w.a + w.b;
      OP_SUB:  return w.a - w.b;
      OP_AND:  return w.a & w.b;
      OP_OR:   return w.a | w.b;
      OP_XOR:  return w.a ^ w.b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic instruction_t rand_word();
    instruction_t w;
    w.a      = $urandom;
    w.b      = $urandom;
    w.opcode = opcode_t'($urandom_range(0, 4));
    return w;
  endfunction

  // External ALU: registers the result of whatever sits on IW one edge later.
  always @(posedge clock) bus.alu_result <= ref_alu(bus.alu_iw);

  // Scoreboard: the n-th accepted word must come back n-th, tagged n mod 2^TAG_W.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      exp_q.delete();
      got_q.delete();
      accept_cnt = 0;
    end else begin
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp_q.push_back('{tag: TAG_W'(accept_cnt % (1 << TAG_W)), res: ref_alu(bus.in_word)});
        accept_cnt++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
        got_q.push_back('{tag: bus.out_tag, res: bus.out_result});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = rand_word();
    bus.out_ready = 1'b1;
    tick();
    tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL rst_out_result: got %h want 0", bus.out_result); end
    total++; if (bus.out_tag !== '0) begin bad++; $display("FAIL rst_out_tag: got %0d want 0", bus.out_tag); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.alu_iw !== '0) begin bad++; $display("FAIL rst_alu_iw: got %h want 0", bus.alu_iw); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single_op();
    instruction_t w;
    do_reset();
    w.a = 32'd5; w.b = 32'd7; w.opcode = OP_ADD;
    bus.in_word = w; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();  // E0: accepted
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_e0: got %b want 1", bus.busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_e0: got %b want 0", bus.out_valid); end
    tick();  // E1: issued
    total++; if (bus.alu_iw !== w) begin bad++; $display("FAIL single_iw: got %h want %h", bus.alu_iw, w); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_e1: got %b want 0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_e2: got %b want 0", bus.out_valid); end
    tick();  // E3: result visible
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid_e3: got %b want 1", bus.out_valid); end
    total++; if (bus.out_result !== 32'd12) begin bad++; $display("FAIL single_result: got %0d want 12", bus.out_result); end
    total++; if (bus.out_tag !== '0) begin bad++; $display("FAIL single_tag: got %0d want 0", bus.out_tag); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_popped: got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    instruction_t w [10];
    int idx = 0;
    logic take;
    do_reset();
    foreach (w[i]) w[i] = rand_word();
    for (int c = 0; c < 15; c++) begin
      bus.in_valid = (idx < 10);
      if (idx < 10) bus.in_word = w[idx];
      take = bus.in_valid && bus.in_ready;
      tick();
      if (take) idx++;
    end
    total++; if (idx !== 8) begin bad++; $display("FAIL bp_accepted: got %0d want 8", idx); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && (idx < 10 || got_q.size() < 10); c++) begin
      bus.in_valid = (idx < 10);
      if (idx < 10) bus.in_word = w[idx];
      take = bus.in_valid && bus.in_ready;
      tick();
      if (take) idx++;
    end
    bus.in_valid = 1'b0;
    total++; if (idx !== 10) begin bad++; $display("FAIL bp_rest_accepted: got %0d want 10", idx); end
    total++; if (got_q.size() !== 10) begin bad++; $display("FAIL bp_count: got %0d want 10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      total++;
      if (got_q[i].tag !== TAG_W'(i) || got_q[i].res !== ref_alu(w[i])) begin
        bad++;
        $display("FAIL bp_order[%0d]: got tag=%0d res=%h want tag=%0d res=%h",
                 i, got_q[i].tag, got_q[i].res, i, ref_alu(w[i]));
      end
    end
  endtask

  task automatic test_streaming();
    int n = 0;
    bit started = 0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c < 16) begin
        bus.in_valid = 1'b1;
        bus.in_word.a = 32'(c); bus.in_word.b = 32'd1; bus.in_word.opcode = OP_ADD;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", c, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
        started = 1;
        total++;
        if (bus.out_result !== 32'(n + 1) || bus.out_tag !== TAG_W'(n)) begin
          bad++;
          $display("FAIL stream_out[%0d]: got res=%0d tag=%0d want res=%0d tag=%0d", n, bus.out_result, bus.out_tag, n + 1, n);
        end
        n++;
      end else if (started && n < 16) begin
        total++; bad++;
        $display("FAIL stream_gap: got out_valid=0 want 1 after %0d results", n);
      end
      tick();
    end
    total++; if (n !== 16) begin bad++; $display("FAIL stream_count: got %0d want 16", n); end
  endtask

  task automatic test_full_with_pop();
    instruction_t w [9];
    int idx = 0;
    logic take;
    do_reset();
    foreach (w[i]) w[i] = rand_word();
    for (int c = 0; c < 15; c++) begin
      bus.in_valid = (idx < 8);
      if (idx < 8) bus.in_word = w[idx];
      take = bus.in_valid && bus.in_ready;
      tick();
      if (take) idx++;
    end
    bus.in_valid = 1'b1;
    bus.in_word  = w[8];
    bus.out_ready = 1'b1;
    tick();  // result pop frees one credit; issue follows on the next edge
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready_issue: got %b want 0", bus.in_ready); end
    tick();
    total++; if (bus.alu_iw !== w[4]) begin bad++; $display("FAIL full_issue_word: got %h want %h", bus.alu_iw, w[4]); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready_after: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40 && got_q.size() < 9; c++) tick();
    total++; if (got_q.size() !== 9) begin bad++; $display("FAIL full_count: got %0d want 9", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 9; i++) begin
      total++;
      if (got_q[i].tag !== TAG_W'(i) || got_q[i].res !== ref_alu(w[i])) begin
        bad++;
        $display("FAIL full_order[%0d]: got tag=%0d res=%h want tag=%0d res=%h",
                 i, got_q[i].tag, got_q[i].res, i, ref_alu(w[i]));
      end
    end
  endtask

  task automatic test_reset_midop();
    instruction_t w;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_word  = rand_word();
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL midop_loaded: got valid=%b busy=%b want 1 1", bus.out_valid, bus.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midop_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midop_busy: got %b want 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midop_in_ready: got %b want 1", bus.in_ready); end
    w = rand_word();
    bus.in_word = w; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL midop_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      total++;
      if (got_q[0].tag !== '0 || got_q[0].res !== ref_alu(w)) begin
        bad++;
        $display("FAIL midop_first: got tag=%0d res=%h want tag=0 res=%h", got_q[0].tag, got_q[0].res, ref_alu(w));
      end
    end
  endtask

  task automatic test_tag_wrap();
    int acc = 0;
    logic take;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 400 && acc < 257; c++) begin
      bus.in_valid = 1'b1;
      bus.in_word  = rand_word();
      take = bus.in_ready;
      tick();
      if (take) acc++;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40 && got_q.size() < 257; c++) tick();
    total++; if (got_q.size() !== 257) begin bad++; $display("FAIL wrap_count: got %0d want 257", got_q.size()); end
    if (got_q.size() == 257 && exp_q.size() == 257) begin
      total++; if (got_q[255].tag !== 8'd255) begin bad++; $display("FAIL wrap_tag256: got %0d want 255", got_q[255].tag); end
      total++; if (got_q[256].tag !== 8'd0) begin bad++; $display("FAIL wrap_tag257: got %0d want 0", got_q[256].tag); end
      for (int i = 0; i < 257; i++) begin
        total++;
        if (got_q[i].tag !== exp_q[i].tag || got_q[i].res !== exp_q[i].res) begin
          bad++;
          $display("FAIL wrap_order[%0d]: got tag=%0d res=%h want tag=%0d res=%h",
                   i, got_q[i].tag, got_q[i].res, exp_q[i].tag, exp_q[i].res);
        end
      end
    end
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    logic [31:0] h_res = '0;
    logic [TAG_W-1:0] h_tag = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (hold) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== h_res || bus.out_tag !== h_tag) begin
          bad++;
          $display("FAIL rand_stable[%0d]: got v=%b res=%h tag=%0d want v=1 res=%h tag=%0d",
                   c, bus.out_valid, bus.out_result, bus.out_tag, h_res, h_tag);
        end
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_word   = rand_word();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      hold  = bus.out_valid && !bus.out_ready;
      h_res = bus.out_result;
      h_tag = bus.out_tag;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && got_q.size() < exp_q.size(); c++) tick();
    tick(); tick();
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand_idle: got busy=%b want 0", bus.busy); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i].tag !== exp_q[i].tag || got_q[i].res !== exp_q[i].res) begin
        bad++;
        $display("FAIL rand_order[%0d]: got tag=%0d res=%h want tag=%0d res=%h",
                 i, got_q[i].tag, got_q[i].res, exp_q[i].tag, exp_q[i].res);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_streaming();
    test_full_with_pop();
    test_reset_midop();
    test_tag_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end
endmodule
